sound_delay_timer: RTL and testbench
====================================

Name: sound_delay_timer

Overview:
- Memory-mapped timer peripheral sitting directly downstream of the IO decode stage. IO qualifies CPU writes/reads in the peripheral window and presents a 2-bit register offset.
- Implements an 8-bit delay timer and an 8-bit sound timer, both decremented at a fixed 60 Hz tick.
- Drives the `beeper` square wave while the sound timer is non-zero.
- Raises a level interrupt, fed to one `hardInterrupt` line, when the delay timer expires.

Parameters:
TICK_DIV, 833333, clk cycles per timer tick (50 MHz / 60 Hz); must be >= 2
TONE_DIV, 62500, clk cycles per beeper half-period (400 Hz at 50 MHz); must be >= 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wrEn  input  1  single-cycle write strobe from IO decode
regAddr  input  2  register offset: 0 DELAY, 1 SOUND, 2 CTRL, 3 STATUS
wrData  input  8  write data (dataBus)
rdData  output  8  combinational read data for current regAddr
beeper  output  1  registered square-wave tone output
timerIrq  output  1  level interrupt request = irqPending & irqEn

Behaviour:
- Reset (async): delay=0, sound=0, irqEn=0, beeperEn=1, irqPending=0, prescaler=0, toneCnt=0, beeper=0, timerIrq=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is a one-cycle pulse on the cycle the count is TICK_DIV-1. It is free-running and not reset by register writes.
- On `tick`: each timer that is non-zero decrements by 1. A timer at 0 stays at 0; no wrap to 255.
- Delay 1->0 via `tick` sets irqPending on the next edge. Writing 0 to DELAY never sets irqPending.
- Write DELAY/SOUND (wrEn, regAddr 0/1): takes effect next edge. A write coinciding with `tick` wins: the written value is loaded undecremented, and the other timer still decrements normally.
- Write CTRL (regAddr 2):
  - bit0 = irqEn.
  - bit1 = beeperEn.
  - bit2 = 1 clears irqPending (W1C).
  - If a set event and a clear hit the same cycle, set wins (pending=1).
- Write STATUS (regAddr 3): ignored.
- rdData is a combinational read:
  - 0: delay
  - 1: sound
  - 2: {5'b0, irqPending, beeperEn, irqEn}
  - 3: {5'b0, irqPending, sound!=0, delay!=0}
- Reads have no side effects.
- Tone FSM has two states:
  - IDLE: beeper=0, toneCnt=0. Moves to RUN when sound!=0 && beeperEn.
  - RUN: toneCnt counts 0..TONE_DIV-1. At TONE_DIV-1 it wraps and beeper toggles, so the first rising edge of beeper lands TONE_DIV cycles after entering RUN.
  - RUN returns to IDLE on the edge after sound==0 or beeperEn==0. Returning to IDLE forces beeper=0 and toneCnt=0, so the phase restarts low on the next entry.
- timerIrq is combinational from registers and stays high until software clears it via W1C or clears irqEn.
- Reset asserted mid-operation returns every register to its reset value immediately (async), and beeper drops to 0 without waiting for a clock.
- Width rules: all counters are unsigned. Prescaler width is $clog2(TICK_DIV) and tone counter width is $clog2(TONE_DIV+1). No overflow is possible by construction.

Decomposition:
- Shared package holds:
  - register offset constants: REG_DELAY=2'd0, REG_SOUND=2'd1, REG_CTRL=2'd2, REG_STATUS=2'd3
  - CTRL bit indices: CTRL_IRQEN=0, CTRL_BEEPEN=1, CTRL_IRQCLR=2
  - tone FSM state encoding: TONE_IDLE=1'b0, TONE_RUN=1'b1
- One natural sub-module, `pulse_divider` (parameter DIV, inputs clk/rst/clr, output one-cycle pulse at DIV-1):
  - instantiated once for the 60 Hz tick with clr tied low;
  - instantiated once for the tone half-period with clr = (state==IDLE).

Test Plan (TICK_DIV=4, TONE_DIV=2):
- Reset, then write DELAY=3, CTRL=0x01 -> delay reads 3,2,1,0 on successive ticks; timerIrq rises the edge after reaching 0; STATUS reads 0x04.
- With pending=1, write CTRL=0x05 (clear) -> timerIrq low next cycle. Repeat with the clear in the same cycle as a 1->0 tick -> pending stays 1.
- Write SOUND=2 with beeperEn=1 -> beeper toggles every 2 clks (first rise 2 clks after entering RUN) for ~8 clks, then drops to 0 and stays 0 once sound=0. With beeperEn=0, beeper stays 0 throughout.
- Write DELAY=5 on the exact tick cycle while DELAY=9 -> reads 5 next cycle (not 8 or 4). SOUND=1 decrements to 0 on that same tick.
- Write DELAY=0 while irqEn=1 -> no interrupt. Tick with delay=0 -> value stays 0, no wrap to 255.
- Assert rst asynchronously mid-tone (beeper=1, sound=7) -> beeper, sound, delay and timerIrq go to 0 before the next clk edge. After release, the prescaler restarts from 0 (first tick after 4 clks).

Source files
------------

// File: rtl/sound_delay_timer_pkg.sv
// Shared constants for the sound/delay timer peripheral: register map,
// CTRL bit positions and tone FSM encoding.
`timescale 1ns/1ps
package sound_delay_timer_pkg;

    localparam logic [1:0] REG_DELAY  = 2'd0;
    localparam logic [1:0] REG_SOUND  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_IRQEN  = 0;
    localparam int CTRL_BEEPEN = 1;
    localparam int CTRL_IRQCLR = 2;

    typedef enum logic {
        TONE_IDLE = 1'b0,
        TONE_RUN  = 1'b1
    } tone_state_e;

endpackage

// File: rtl/sound_delay_timer_pulse_divider.sv
// Free-running modulo-DIV counter emitting a one-cycle pulse at count DIV-1.
// clr holds the count at zero and suppresses the pulse.
`timescale 1ns/1ps
module pulse_divider #(
    parameter int DIV = 2,
    parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pulse
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        pulse = !clr && (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        if (clr || pulse) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sound_delay_timer.sv
// 60 Hz delay/sound timer peripheral with beeper tone and delay-expiry interrupt.
// Tone FSM:  TONE_IDLE | beeper low, tone counter held at 0
//            TONE_RUN  | tone counter running, beeper toggles each half-period
`timescale 1ns/1ps
module sound_delay_timer
    import sound_delay_timer_pkg::*;
#(
    parameter int TICK_DIV = 833333,
    parameter int TONE_DIV = 62500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrEn,
    input  logic [1:0] regAddr,
    input  logic [7:0] wrData,
    output logic [7:0] rdData,
    output logic       beeper,
    output logic       timerIrq
);

    logic        tick;
    logic        tone_pulse;
    tone_state_e state_q, state_d;
    logic [7:0]  delay_q, delay_d;
    logic [7:0]  sound_q, sound_d;
    logic        irq_en_q, irq_en_d;
    logic        beep_en_q, beep_en_d;
    logic        pend_q, pend_d;
    logic        beeper_q, beeper_d;
    logic        wr_delay, wr_sound, wr_ctrl, irq_set;

    pulse_divider #(.DIV(TICK_DIV), .W($clog2(TICK_DIV))) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .pulse (tick)
    );

    pulse_divider #(.DIV(TONE_DIV), .W($clog2(TONE_DIV + 1))) u_tone (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == TONE_IDLE),
        .pulse (tone_pulse)
    );

    always_comb begin
        wr_delay  = wrEn && (regAddr == REG_DELAY);
        wr_sound  = wrEn && (regAddr == REG_SOUND);
        wr_ctrl   = wrEn && (regAddr == REG_CTRL);

        delay_d = delay_q;
        if (wr_delay) begin
            delay_d = wrData;
        end else if (tick && (delay_q != 8'd0)) begin
            delay_d = delay_q - 8'd1;
        end

        sound_d = sound_q;
        if (wr_sound) begin
            sound_d = wrData;
        end else if (tick && (sound_q != 8'd0)) begin
            sound_d = sound_q - 8'd1;
        end

        // A DELAY write on the tick cycle pre-empts the 1->0 expiry.
        irq_set = tick && !wr_delay && (delay_q == 8'd1);

        irq_en_d  = wr_ctrl ? wrData[CTRL_IRQEN]  : irq_en_q;
        beep_en_d = wr_ctrl ? wrData[CTRL_BEEPEN] : beep_en_q;

        pend_d = pend_q;
        if (irq_set) begin
            pend_d = 1'b1;
        end else if (wr_ctrl && wrData[CTRL_IRQCLR]) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        beeper_d = 1'b0;
        case (state_q)
            TONE_IDLE: begin
                if ((sound_q != 8'd0) && beep_en_q) begin
                    state_d = TONE_RUN;
                end
            end
            TONE_RUN: begin
                if ((sound_q == 8'd0) || !beep_en_q) begin
                    state_d = TONE_IDLE;
                end else begin
                    beeper_d = tone_pulse ? !beeper_q : beeper_q;
                end
            end
            default: state_d = TONE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TONE_IDLE;
            delay_q   <= 8'd0;
            sound_q   <= 8'd0;
            irq_en_q  <= 1'b0;
            beep_en_q <= 1'b1;
            pend_q    <= 1'b0;
            beeper_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            sound_q   <= sound_d;
            irq_en_q  <= irq_en_d;
            beep_en_q <= beep_en_d;
            pend_q    <= pend_d;
            beeper_q  <= beeper_d;
        end
    end

    always_comb begin
        case (regAddr)
            REG_DELAY:  rdData = delay_q;
            REG_SOUND:  rdData = sound_q;
            REG_CTRL:   rdData = {5'b0, pend_q, beep_en_q, irq_en_q};
            REG_STATUS: rdData = {5'b0, pend_q, sound_q != 8'd0, delay_q != 8'd0};
            default:    rdData = 8'd0;
        endcase
    end

    assign beeper   = beeper_q;
    assign timerIrq = pend_q & irq_en_q;

endmodule

// File: tb/tb_sound_delay_timer.sv
// Directed bench for sound_delay_timer with TICK_DIV=4, TONE_DIV=2.
`timescale 1ns/1ps
module tb_sound_delay_timer;

    localparam logic [1:0] A_DELAY  = 2'd0;
    localparam logic [1:0] A_SOUND  = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrEn = 1'b0;
    logic [1:0] regAddr = 2'd0;
    logic [7:0] wrData = 8'd0;
    logic [7:0] rdData;
    logic       beeper;
    logic       timerIrq;

    int checks = 0;
    int errors = 0;
    int pc_m;

    sound_delay_timer #(.TICK_DIV(4), .TONE_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .regAddr  (regAddr),
        .wrData   (wrData),
        .rdData   (rdData),
        .beeper   (beeper),
        .timerIrq (timerIrq)
    );

    always #5 clk = ~clk;

    // Reference prescaler phase: tick cycle is the one where pc_m == 3.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_m <= 0;
        else     pc_m <= (pc_m == 3) ? 0 : pc_m + 1;
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        regAddr = a;
        wrData  = d;
        wrEn    = 1'b1;
        @(negedge clk);
        wrEn    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        regAddr = a;
        #1;
        v = rdData;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (pc_m != 3 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (pc_m != 3) begin
            checks++;
            errors++;
            $display("FAIL wait_tick timeout got phase %0d want 3", pc_m);
        end
    endtask

    task automatic next_tick();
        wait_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rd(A_DELAY, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_delay got %0h want 00", v); end
        rd(A_SOUND, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_sound got %0h want 00", v); end
        rd(A_CTRL, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL reset_ctrl got %0h want 02", v); end
        rd(A_STATUS, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_status got %0h want 00", v); end
        checks++; if (beeper !== 1'b0) begin errors++; $display("FAIL reset_beeper got %b want 0", beeper); end
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", timerIrq); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_delay_irq();
        logic [7:0] v;
        wr(A_CTRL, 8'h01);
        wr(A_DELAY, 8'd3);
        rd(A_DELAY, v);
        checks++; if (v !== 8'd3) begin errors++; $display("FAIL delay_load got %0d want 3", v); end
        next_tick();
        rd(A_DELAY, v);
        checks++; if (v !== 8'd2) begin errors++; $display("FAIL delay_tick1 got %0d want 2", v); end
        next_tick();
        rd(A_DELAY, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL delay_tick2 got %0d want 1", v); end
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", timerIrq); end
        next_tick();
        rd(A_DELAY, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL delay_tick3 got %0d want 0", v); end
        checks++; if (timerIrq !== 1'b1) begin errors++; $display("FAIL irq_expire got %b want 1", timerIrq); end
        rd(A_STATUS, v);
        checks++; if (v !== 8'h04) begin errors++; $display("FAIL status_expire got %0h want 04", v); end
        rd(A_CTRL, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL ctrl_expire got %0h want 05", v); end
    endtask

    task automatic test_irq_clear();
        logic [7:0] v;
        wr(A_CTRL, 8'h05);
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b want 0", timerIrq); end
        rd(A_STATUS, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL w1c_status got %0h want 00", v); end
        wr(A_DELAY, 8'd1);
        wait_tick();
        wr(A_CTRL, 8'h05);
        checks++; if (timerIrq !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b want 1", timerIrq); end
        rd(A_DELAY, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL set_beats_clear_delay got %0d want 0", v); end
    endtask

    task automatic test_sound();
        logic [7:0] v;
        logic       exp_b [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        wr(A_CTRL, 8'h07);
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL sound_pre_irq got %b want 0", timerIrq); end
        wait_tick();
        wr(A_SOUND, 8'd2);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (beeper !== exp_b[i]) begin
                errors++;
                $display("FAIL tone_wave cycle %0d got %b want %b", i, beeper, exp_b[i]);
            end
            @(negedge clk);
        end
        rd(A_SOUND, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL sound_done got %0d want 0", v); end
        wr(A_CTRL, 8'h01);
        wr(A_SOUND, 8'd2);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (beeper !== 1'b0) begin
                errors++;
                $display("FAIL tone_disabled cycle %0d got %b want 0", i, beeper);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_tick();
        logic [7:0] v;
        next_tick();
        wr(A_DELAY, 8'd9);
        wr(A_SOUND, 8'd1);
        wait_tick();
        wr(A_DELAY, 8'd5);
        rd(A_DELAY, v);
        checks++; if (v !== 8'd5) begin errors++; $display("FAIL write_on_tick_delay got %0d want 5", v); end
        rd(A_SOUND, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL write_on_tick_sound got %0d want 0", v); end
    endtask

    task automatic test_zero();
        logic [7:0] v;
        wr(A_DELAY, 8'd0);
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL zero_write_irq got %b want 0", timerIrq); end
        repeat (10) @(negedge clk);
        rd(A_DELAY, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL zero_no_wrap got %0d want 0", v); end
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL zero_tick_irq got %b want 0", timerIrq); end
        wr(A_STATUS, 8'hFF);
        rd(A_CTRL, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL status_write_ignored got %0h want 01", v); end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        int         n = 0;
        wr(A_DELAY, 8'd9);
        wr(A_CTRL, 8'h03);
        wr(A_SOUND, 8'd7);
        while (beeper !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (beeper !== 1'b1) begin errors++; $display("FAIL tone_start got %b want 1", beeper); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (beeper !== 1'b0) begin errors++; $display("FAIL async_beeper got %b want 0", beeper); end
        checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL async_irq got %b want 0", timerIrq); end
        rd(A_SOUND, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL async_sound got %0d want 0", v); end
        rd(A_DELAY, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL async_delay got %0d want 0", v); end
        @(negedge clk);
        rst = 1'b0;
        wr(A_DELAY, 8'd2);
        @(negedge clk);
        @(negedge clk);
        rd(A_DELAY, v);
        checks++; if (v !== 8'd2) begin errors++; $display("FAIL prescaler_restart_pre got %0d want 2", v); end
        @(negedge clk);
        rd(A_DELAY, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL prescaler_restart_tick got %0d want 1", v); end
        rd(A_CTRL, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL post_reset_ctrl got %0h want 02", v); end
    endtask

    initial begin
        test_reset();
        test_delay_irq();
        test_irq_clear();
        test_sound();
        test_write_tick();
        test_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
